// File: rtl/neuron_layer_sequencer_if.sv
// Bus bundle between a neuron-layer sequencer and its surroundings:
// config loader, input stream, neuron bank and output stream.
interface neuron_layer_sequencer_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_NEURONS = 4
);
    logic                              cfg_valid_i;
    logic                              cfg_ready_o;
    logic [31:0]                       cfg_data_i;
    logic                              cfg_start_i;
    logic                              in_valid_i;
    logic                              in_ready_o;
    logic [DATA_WIDTH-1:0]             in_data_i;
    logic                              weight_valid_o;
    logic                              bias_valid_o;
    logic [31:0]                       weight_value_o;
    logic [31:0]                       bias_value_o;
    logic [31:0]                       cfg_layer_num_o;
    logic [31:0]                       cfg_neuron_num_o;
    logic                              neuron_in_valid_o;
    logic [DATA_WIDTH-1:0]             neuron_in_o;
    logic [NUM_NEURONS-1:0]            neuron_out_valid_i;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out_i;
    logic                              out_valid_o;
    logic                              out_ready_i;
    logic [DATA_WIDTH-1:0]             out_data_o;
    logic                              out_last_o;
    logic                              busy_o;
    logic                              timeout_err_o;

    modport slave (
        input  cfg_valid_i, cfg_data_i, cfg_start_i, in_valid_i, in_data_i,
               neuron_out_valid_i, neuron_out_i, out_ready_i,
        output cfg_ready_o, in_ready_o, weight_valid_o, bias_valid_o,
               weight_value_o, bias_value_o, cfg_layer_num_o, cfg_neuron_num_o,
               neuron_in_valid_o, neuron_in_o, out_valid_o, out_data_o,
               out_last_o, busy_o, timeout_err_o
    );

    modport master (
        output cfg_valid_i, cfg_data_i, cfg_start_i, in_valid_i, in_data_i,
               neuron_out_valid_i, neuron_out_i, out_ready_i,
        input  cfg_ready_o, in_ready_o, weight_valid_o, bias_valid_o,
               weight_value_o, bias_value_o, cfg_layer_num_o, cfg_neuron_num_o,
               neuron_in_valid_o, neuron_in_o, out_valid_o, out_data_o,
               out_last_o, busy_o, timeout_err_o
    );
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Layer controller: loads neuron weights/biases, broadcasts input vectors,
// gathers per-neuron results and serialises them onto the output stream.
module neuron_layer_sequencer #(
    parameter int unsigned LAYER_NUM   = 0,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned TIMEOUT     = 64
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    neuron_layer_sequencer_if.slave bus
);
    localparam int unsigned NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int unsigned IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned WW = $clog2(NUM_INPUTS + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [NW-1:0] LAST_NEURON = NW'(NUM_NEURONS - 1);
    localparam logic [IW-1:0] LAST_INPUT  = IW'(NUM_INPUTS - 1);
    localparam logic [WW-1:0] BIAS_SLOT   = WW'(NUM_INPUTS);
    localparam logic [TW-1:0] LAST_TICK   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_CONFIG, S_FEED, S_WAIT, S_DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [NW-1:0]          nc_q, nc_d;
    logic [WW-1:0]          wc_q, wc_d;
    logic [IW-1:0]          in_cnt_q, in_cnt_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [NW-1:0]          idx_q, idx_d;
    logic [NUM_NEURONS-1:0] done_q, done_d;
    logic [DATA_WIDTH-1:0]  res_q [NUM_NEURONS];
    logic [DATA_WIDTH-1:0]  res_d [NUM_NEURONS];

    logic                   cfg_ready_q, cfg_ready_d;
    logic                   in_ready_q, in_ready_d;
    logic                   weight_valid_q, weight_valid_d;
    logic                   bias_valid_q, bias_valid_d;
    logic [31:0]            weight_value_q, weight_value_d;
    logic [31:0]            bias_value_q, bias_value_d;
    logic [31:0]            cfg_neuron_num_q, cfg_neuron_num_d;
    logic                   neuron_in_valid_q, neuron_in_valid_d;
    logic [DATA_WIDTH-1:0]  neuron_in_q, neuron_in_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   timeout_err_q, timeout_err_d;

    logic                   start_block_c;
    logic                   in_ready_c;
    logic                   cfg_acc_c;
    logic                   in_acc_c;
    logic                   out_acc_c;

    // A reload request at a vector boundary must win over a coincident sample.
    assign start_block_c = bus.cfg_start_i && (in_cnt_q == '0);
    assign in_ready_c    = in_ready_q && !start_block_c;
    assign cfg_acc_c     = bus.cfg_valid_i && cfg_ready_q;
    assign in_acc_c      = bus.in_valid_i && in_ready_c;
    assign out_acc_c     = out_valid_q && bus.out_ready_i;

    always_comb begin
        state_d           = state_q;
        nc_d              = nc_q;
        wc_d              = wc_q;
        in_cnt_d          = in_cnt_q;
        timer_d           = timer_q;
        idx_d             = idx_q;
        done_d            = done_q;
        res_d             = res_q;
        weight_valid_d    = 1'b0;
        bias_valid_d      = 1'b0;
        weight_value_d    = weight_value_q;
        bias_value_d      = bias_value_q;
        cfg_neuron_num_d  = cfg_neuron_num_q;
        neuron_in_valid_d = 1'b0;
        neuron_in_d       = neuron_in_q;
        timeout_err_d     = timeout_err_q;

        // Early results arriving while inputs are still streaming are kept too.
        if ((state_q == S_FEED) || (state_q == S_WAIT)) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (bus.neuron_out_valid_i[k]) begin
                    done_d[k] = 1'b1;
                    res_d[k]  = bus.neuron_out_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        case (state_q)
            S_CONFIG: begin
                if (cfg_acc_c) begin
                    cfg_neuron_num_d = 32'(nc_q);
                    if (wc_q == BIAS_SLOT) begin
                        bias_valid_d = 1'b1;
                        bias_value_d = bus.cfg_data_i;
                        wc_d         = '0;
                        if (nc_q == LAST_NEURON) begin
                            nc_d    = '0;
                            state_d = S_FEED;
                        end else begin
                            nc_d = nc_q + NW'(1);
                        end
                    end else begin
                        weight_valid_d = 1'b1;
                        weight_value_d = bus.cfg_data_i;
                        wc_d           = wc_q + WW'(1);
                    end
                end
            end
            S_FEED: begin
                if (start_block_c) begin
                    state_d = S_CONFIG;
                    nc_d    = '0;
                    wc_d    = '0;
                    timer_d = '0;
                end else if (in_acc_c) begin
                    neuron_in_valid_d = 1'b1;
                    neuron_in_d       = bus.in_data_i;
                    if (in_cnt_q == LAST_INPUT) begin
                        in_cnt_d = '0;
                        timer_d  = '0;
                        state_d  = S_WAIT;
                    end else begin
                        in_cnt_d = in_cnt_q + IW'(1);
                    end
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (&done_d) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else if (timer_q == LAST_TICK) begin
                    state_d       = S_DRAIN;
                    idx_d         = '0;
                    timeout_err_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_acc_c) begin
                    if (idx_q == LAST_NEURON) begin
                        state_d = S_FEED;
                        idx_d   = '0;
                        done_d  = '0;
                        for (int k = 0; k < NUM_NEURONS; k++) begin
                            res_d[k] = '0;
                        end
                    end else begin
                        idx_d = idx_q + NW'(1);
                    end
                end
            end
            default: state_d = S_CONFIG;
        endcase

        // Status outputs are registered from the next-state view.
        cfg_ready_d = (state_d == S_CONFIG);
        in_ready_d  = (state_d == S_FEED);
        out_valid_d = (state_d == S_DRAIN);
        out_data_d  = (state_d == S_DRAIN) ? res_d[idx_d] : '0;
        out_last_d  = (state_d == S_DRAIN) && (idx_d == LAST_NEURON);
        busy_d      = (state_d != S_FEED) || (in_cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q           <= S_CONFIG;
            nc_q              <= '0;
            wc_q              <= '0;
            in_cnt_q          <= '0;
            timer_q           <= '0;
            idx_q             <= '0;
            done_q            <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                res_q[k] <= '0;
            end
            cfg_ready_q       <= 1'b0;
            in_ready_q        <= 1'b0;
            weight_valid_q    <= 1'b0;
            bias_valid_q      <= 1'b0;
            weight_value_q    <= '0;
            bias_value_q      <= '0;
            cfg_neuron_num_q  <= '0;
            neuron_in_valid_q <= 1'b0;
            neuron_in_q       <= '0;
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_last_q        <= 1'b0;
            busy_q            <= 1'b0;
            timeout_err_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            nc_q              <= nc_d;
            wc_q              <= wc_d;
            in_cnt_q          <= in_cnt_d;
            timer_q           <= timer_d;
            idx_q             <= idx_d;
            done_q            <= done_d;
            res_q             <= res_d;
            cfg_ready_q       <= cfg_ready_d;
            in_ready_q        <= in_ready_d;
            weight_valid_q    <= weight_valid_d;
            bias_valid_q      <= bias_valid_d;
            weight_value_q    <= weight_value_d;
            bias_value_q      <= bias_value_d;
            cfg_neuron_num_q  <= cfg_neuron_num_d;
            neuron_in_valid_q <= neuron_in_valid_d;
            neuron_in_q       <= neuron_in_d;
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
            out_last_q        <= out_last_d;
            busy_q            <= busy_d;
            timeout_err_q     <= timeout_err_d;
        end
    end

    assign bus.cfg_ready_o       = cfg_ready_q;
    assign bus.in_ready_o        = in_ready_c;
    assign bus.weight_valid_o    = weight_valid_q;
    assign bus.bias_valid_o      = bias_valid_q;
    assign bus.weight_value_o    = weight_value_q;
    assign bus.bias_value_o      = bias_value_q;
    assign bus.cfg_layer_num_o   = 32'(LAYER_NUM);
    assign bus.cfg_neuron_num_o  = cfg_neuron_num_q;
    assign bus.neuron_in_valid_o = neuron_in_valid_q;
    assign bus.neuron_in_o       = neuron_in_q;
    assign bus.out_valid_o       = out_valid_q;
    assign bus.out_data_o        = out_data_q;
    assign bus.out_last_o        = out_last_q;
    assign bus.busy_o            = busy_q;
    assign bus.timeout_err_o     = timeout_err_q;
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer: 2 neurons x 3 inputs, short timeout.
module tb_neuron_layer_sequencer;
    localparam int unsigned DW = 16;
    localparam int unsigned NN = 2;
    localparam int unsigned NI = 3;
    localparam int unsigned TO = 8;
    localparam int unsigned LN = 5;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    neuron_layer_sequencer_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) bus ();

    neuron_layer_sequencer #(
        .LAYER_NUM(LN), .NUM_NEURONS(NN), .NUM_INPUTS(NI),
        .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] off;
        logic        exp_w;
        logic        exp_b;
        logic [31:0] exp_nrn;
    } cfg_vec_t;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_last;
    } drain_vec_t;

    cfg_vec_t    cfg_tab   [8];
    logic [15:0] feed_tab  [3];
    drain_vec_t  drain_tab [4];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_config(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            bus.cfg_valid_i = 1'b1;
            bus.cfg_data_i  = base + cfg_tab[i].off;
            check("cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
            tick();
            check("weight_valid", 32'(bus.weight_valid_o), 32'(cfg_tab[i].exp_w));
            check("bias_valid", 32'(bus.bias_valid_o), 32'(cfg_tab[i].exp_b));
            if (cfg_tab[i].exp_b) check("bias_value", bus.bias_value_o, base + cfg_tab[i].off);
            else                  check("weight_value", bus.weight_value_o, base + cfg_tab[i].off);
            check("cfg_neuron", bus.cfg_neuron_num_o, cfg_tab[i].exp_nrn);
        end
        bus.cfg_valid_i = 1'b0;
        check("cfg_ready_drop", 32'(bus.cfg_ready_o), 32'd0);
        check("in_ready_feed", 32'(bus.in_ready_o), 32'd1);
        tick();
        check("bias_pulse_width", 32'(bus.bias_valid_o), 32'd0);
    endtask

    task automatic feed(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = feed_tab[i];
            check("in_ready", 32'(bus.in_ready_o), 32'd1);
            tick();
            check("nin_valid", 32'(bus.neuron_in_valid_o), 32'd1);
            check("nin_data", 32'(bus.neuron_in_o), 32'(feed_tab[i]));
            check("busy_feed", 32'(bus.busy_o), 32'd1);
            bus.in_valid_i = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                check("nin_pulse_width", 32'(bus.neuron_in_valid_o), 32'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cfg_tab[0] = '{32'd0, 1'b1, 1'b0, 32'd0};
        cfg_tab[1] = '{32'd1, 1'b1, 1'b0, 32'd0};
        cfg_tab[2] = '{32'd2, 1'b1, 1'b0, 32'd0};
        cfg_tab[3] = '{32'd3, 1'b0, 1'b1, 32'd0};
        cfg_tab[4] = '{32'd4, 1'b1, 1'b0, 32'd1};
        cfg_tab[5] = '{32'd5, 1'b1, 1'b0, 32'd1};
        cfg_tab[6] = '{32'd6, 1'b1, 1'b0, 32'd1};
        cfg_tab[7] = '{32'd7, 1'b0, 1'b1, 32'd1};
        feed_tab[0] = 16'd3;
        feed_tab[1] = 16'd5;
        feed_tab[2] = 16'd7;
        drain_tab[0] = '{1'b0, 1'b1, 16'h0011, 1'b0};
        drain_tab[1] = '{1'b1, 1'b1, 16'h0022, 1'b1};
        drain_tab[2] = '{1'b0, 1'b1, 16'h0022, 1'b1};
        drain_tab[3] = '{1'b1, 1'b0, 16'h0000, 1'b0};

        rst_ni                 = 1'b0;
        bus.cfg_valid_i        = 1'b0;
        bus.cfg_data_i         = '0;
        bus.cfg_start_i        = 1'b0;
        bus.in_valid_i         = 1'b0;
        bus.in_data_i          = '0;
        bus.neuron_out_valid_i = '0;
        bus.neuron_out_i       = '0;
        bus.out_ready_i        = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cfg_ready", 32'(bus.cfg_ready_o), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_timeout", 32'(bus.timeout_err_o), 32'd0);
        check("layer_num", bus.cfg_layer_num_o, 32'd5);
        rst_ni = 1'b1;
        tick();
        check("cfg_ready_post_rst", 32'(bus.cfg_ready_o), 32'd1);
        check("busy_config", 32'(bus.busy_o), 32'd1);

        // 1: config words 0x10..0x17
        do_config(32'h10);
        check("busy_idle_feed", 32'(bus.busy_o), 32'd0);

        // 2: feed 3,5,7 with gaps
        feed(3, 1);
        check("in_ready_wait", 32'(bus.in_ready_o), 32'd0);
        check("busy_wait", 32'(bus.busy_o), 32'd1);

        // 3: out-of-order results, drain with toggling ready
        bus.neuron_out_valid_i = 2'b10;
        bus.neuron_out_i       = {16'h0022, 16'h0000};
        tick();
        bus.neuron_out_valid_i = 2'b00;
        check("no_drain_partial", 32'(bus.out_valid_o), 32'd0);
        tick();
        bus.neuron_out_valid_i = 2'b01;
        bus.neuron_out_i       = {16'h0000, 16'h0011};
        tick();
        bus.neuron_out_valid_i = 2'b00;
        check("drain_valid0", 32'(bus.out_valid_o), 32'd1);
        check("drain_data0", 32'(bus.out_data_o), 32'h11);
        check("drain_last0", 32'(bus.out_last_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.out_ready_i = drain_tab[i].ready;
            tick();
            check("drain_valid", 32'(bus.out_valid_o), 32'(drain_tab[i].exp_valid));
            check("drain_data", 32'(bus.out_data_o), 32'(drain_tab[i].exp_data));
            check("drain_last", 32'(bus.out_last_o), 32'(drain_tab[i].exp_last));
        end
        bus.out_ready_i = 1'b0;
        check("busy_after_drain", 32'(bus.busy_o), 32'd0);
        check("no_timeout_yet", 32'(bus.timeout_err_o), 32'd0);

        // 4: only neuron 0 answers -> timeout after 8 WAIT cycles
        feed(3, 0);
        bus.neuron_out_valid_i = 2'b01;
        bus.neuron_out_i       = {16'h0000, 16'h00aa};
        tick();
        bus.neuron_out_valid_i = 2'b00;
        n = 0;
        while (bus.out_valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("timeout_latency", 32'(n), 32'd7);
        check("timeout_err", 32'(bus.timeout_err_o), 32'd1);
        check("to_data0", 32'(bus.out_data_o), 32'haa);
        check("to_last0", 32'(bus.out_last_o), 32'd0);
        bus.out_ready_i = 1'b1;
        tick();
        check("to_data1", 32'(bus.out_data_o), 32'h0);
        check("to_last1", 32'(bus.out_last_o), 32'd1);
        tick();
        bus.out_ready_i = 1'b0;
        check("to_drain_done", 32'(bus.out_valid_o), 32'd0);
        check("to_sticky", 32'(bus.timeout_err_o), 32'd1);

        // 5: cfg_start at vector boundary blocks the coincident sample
        bus.cfg_start_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 16'h0055;
        #1;
        check("start_blocks_ready", 32'(bus.in_ready_o), 32'd0);
        tick();
        bus.cfg_start_i = 1'b0;
        bus.in_valid_i  = 1'b0;
        check("start_cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
        check("start_no_sample", 32'(bus.neuron_in_valid_o), 32'd0);
        check("start_busy", 32'(bus.busy_o), 32'd1);
        check("start_sticky", 32'(bus.timeout_err_o), 32'd1);

        // 6: reset mid-vector, then a clean full pass
        do_config(32'h20);
        feed(2, 0);
        rst_ni = 1'b0;
        tick();
        check("mid_rst_nin_valid", 32'(bus.neuron_in_valid_o), 32'd0);
        check("mid_rst_nin", 32'(bus.neuron_in_o), 32'd0);
        check("mid_rst_cfg_ready", 32'(bus.cfg_ready_o), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        check("mid_rst_weight", bus.weight_value_o, 32'd0);
        check("mid_rst_bias", bus.bias_value_o, 32'd0);
        check("mid_rst_neuron", bus.cfg_neuron_num_o, 32'd0);
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_timeout", 32'(bus.timeout_err_o), 32'd0);
        check("mid_rst_layer", bus.cfg_layer_num_o, 32'd5);
        rst_ni = 1'b1;
        tick();
        check("re_cfg_ready", 32'(bus.cfg_ready_o), 32'd1);
        do_config(32'h30);
        feed(3, 0);
        bus.neuron_out_valid_i = 2'b11;
        bus.neuron_out_i       = {16'h00bb, 16'h00cc};
        tick();
        bus.neuron_out_valid_i = 2'b00;
        check("fin_valid0", 32'(bus.out_valid_o), 32'd1);
        check("fin_data0", 32'(bus.out_data_o), 32'hcc);
        bus.out_ready_i = 1'b1;
        tick();
        check("fin_valid1", 32'(bus.out_valid_o), 32'd1);
        check("fin_data1", 32'(bus.out_data_o), 32'hbb);
        check("fin_last1", 32'(bus.out_last_o), 32'd1);
        tick();
        bus.out_ready_i = 1'b0;
        check("fin_done", 32'(bus.out_valid_o), 32'd0);
        check("fin_busy", 32'(bus.busy_o), 32'd0);
        check("fin_no_timeout", 32'(bus.timeout_err_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
